// File: rtl/sa_pkg.sv
// Shared systolic-array constants: column result width and column-packing helpers.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package sa_pkg;

   // Default width of one signed column result leaving the array
   localparam int SA_DATA_WIDTH = 32;

   // Default number of array columns
   localparam int SA_N_COLS = 4;

   // LSB of column `col` in a packed column vector (column 0 at the bottom)
   function automatic int sa_col_lsb(input int col, input int width);
      return col * width;
   endfunction

   // MSB of column `col` in a packed column vector
   function automatic int sa_col_msb(input int col, input int width);
      return col * width + width - 1;
   endfunction

endpackage

// File: rtl/sa_vec_fifo.sv
// Vector FIFO holding DEPTH aligned column vectors; head is registered storage, no bypass.
// Latency: a push is visible at the head one edge later when the FIFO was empty.
// Backpressure: push while full is dropped unless a pop happens on the same edge; pop when empty is ignored.
module sa_vec_fifo #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_dat,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_dat,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = 1;
   localparam logic [AW:0]   CNT_ONE  = 1;
   localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             do_push, do_pop;

   // Pointer/count bookkeeping; pointers wrap naturally since DEPTH is a power of two
   always_comb begin
      empty    = (cnt_q == '0);
      full     = (cnt_q == CNT_FULL);
      do_pop   = pop & ~empty;
      do_push  = push & (~full | do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      mem_d    = mem_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_dat;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end
   end

   // State registers; storage is reset too so the head never carries X
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         mem_q    <= mem_d;
      end
   end

   // Head is forced to zero while empty so stale vectors are never presented
   always_comb begin
      head_dat = empty ? '0 : mem_q[rd_ptr_q];
      count    = cnt_q;
   end

endmodule

// File: rtl/sa_deskew.sv
// Deskews systolic-array column outputs: column c is delayed N_COLS-c stages, aligned vectors are queued.
// Latency: column c valid in cycle T+c gives out_valid in cycle T+N_COLS+1 (empty FIFO).
// Backpressure: valid/ready on the output; a vector arriving while full with no pop is dropped and flagged.
module sa_deskew
   import sa_pkg::*;
#(
   parameter int DATA_WIDTH = SA_DATA_WIDTH,
   parameter int N_COLS     = SA_N_COLS,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                            DSK_clk,
   input  logic                            DSK_rst_n,
   input  logic                            DSK_mode,
   input  logic [N_COLS-1:0]               DSK_en_in,
   input  logic [N_COLS*DATA_WIDTH-1:0]    DSK_data_in,
   input  logic                            DSK_clr,
   output logic                            DSK_out_valid,
   input  logic                            DSK_out_ready,
   output logic [N_COLS*DATA_WIDTH-1:0]    DSK_out_data,
   output logic [$clog2(FIFO_DEPTH):0]     DSK_count,
   output logic                            DSK_err,
   output logic                            DSK_ovf
);

   localparam int VW = N_COLS * DATA_WIDTH;

   logic [N_COLS-1:0] al_en;
   logic [VW-1:0]     al_dat;
   logic              all_en, any_en;
   logic              push, pop;
   logic              fifo_full, fifo_empty;
   logic              err_q, err_d;
   logic              ovf_q, ovf_d;

   generate
      for (genvar c = 0; c < N_COLS; c++) begin : g_col
         localparam int NST = N_COLS - c;
         localparam int LSB = sa_col_lsb(c, DATA_WIDTH);

         logic [NST-1:0]        en_q, en_d;
         logic [DATA_WIDTH-1:0] dat_q [NST];
         logic [DATA_WIDTH-1:0] dat_d [NST];
         logic [NST:0]          en_src;
         logic [DATA_WIDTH-1:0] dat_src [NST+1];

         // Source of each stage: index 0 is the mode-gated input, index s+1 is stage s
         always_comb begin
            en_src[0]  = DSK_en_in[c] & ~DSK_mode;
            dat_src[0] = DSK_data_in[LSB +: DATA_WIDTH];
            for (int s = 0; s < NST; s++) begin
               en_src[s+1]  = en_q[s];
               dat_src[s+1] = dat_q[s];
            end
         end

         // Enables shift every edge; data only loads alongside a set enable
         always_comb begin
            for (int s = 0; s < NST; s++) begin
               en_d[s]  = en_src[s] & ~DSK_clr;
               dat_d[s] = en_src[s] ? dat_src[s] : dat_q[s];
            end
         end

         // Delay-line registers
         always_ff @(posedge DSK_clk or negedge DSK_rst_n) begin
            if (!DSK_rst_n) begin
               en_q <= '0;
               for (int s = 0; s < NST; s++) begin
                  dat_q[s] <= '0;
               end
            end else begin
               en_q  <= en_d;
               dat_q <= dat_d;
            end
         end

         assign al_en[c]                    = en_src[NST];
         assign al_dat[LSB +: DATA_WIDTH]   = dat_src[NST];
      end
   endgenerate

   // Classify the aligned vector and update sticky flags; clear wins over everything
   always_comb begin
      all_en = &al_en;
      any_en = |al_en;
      push   = all_en & ~DSK_clr;
      pop    = ~fifo_empty & DSK_out_ready & ~DSK_clr;
      err_d  = err_q;
      ovf_d  = ovf_q;
      if (any_en & ~all_en) begin
         err_d = 1'b1;
      end
      if (push & fifo_full & ~pop) begin
         ovf_d = 1'b1;
      end
      if (DSK_clr) begin
         err_d = 1'b0;
         ovf_d = 1'b0;
      end
   end

   // Sticky flag registers
   always_ff @(posedge DSK_clk or negedge DSK_rst_n) begin
      if (!DSK_rst_n) begin
         err_q <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         err_q <= err_d;
         ovf_q <= ovf_d;
      end
   end

   sa_vec_fifo #(
      .WIDTH (VW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (DSK_clk),
      .rst_n    (DSK_rst_n),
      .clr      (DSK_clr),
      .push     (push),
      .push_dat (al_dat),
      .pop      (pop),
      .head_dat (DSK_out_data),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (DSK_count)
   );

   assign DSK_out_valid = ~fifo_empty;
   assign DSK_err       = err_q;
   assign DSK_ovf       = ovf_q;

endmodule
